// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the video RAM arbiter.
// Requester ids travel down the read pipeline; the FSM state covers the write sequence.
// No ports: this is a package imported by vram_arbiter and vram_arb_priority.
package vram_arb_pkg;

  localparam int RD_LATENCY = 2;  // grant -> rvalid, in cycles
  localparam int WR_CYCLES  = 3;  // setup, strobe, hold

  typedef enum logic [1:0] {REQ_NONE, REQ_BG, REQ_SPR, REQ_CPU} reqId_e;

  // One state per write phase plus IDLE.
  typedef enum logic [$clog2(WR_CYCLES+1)-1:0] {IDLE, WR_SETUP, WR_STROBE, WR_HOLD} state_e;

  // Grants are only legal when the SRAM pins are free for the next cycle.
  function automatic logic grantWindow(state_e s);
    return (s == IDLE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/vram_arb_priority.sv
// Purpose: picks one requester per cycle (BG > SPR > CPU, CPU first once starved).
// Latency: combinational winner; the starvation counter is the only register.
// Backpressure: losers simply see no winner id and keep their request asserted.
// Ports: clk/rst, grantEn (pins free this cycle), bgReq/sprReq/cpuReq, winner id out.
module vram_arb_priority
  import vram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   grantEn,
  input  logic   bgReq,
  input  logic   sprReq,
  input  logic   cpuReq,
  output reqId_e winner
);

  logic [7:0] starveCnt;
  logic       starved;

  assign starved = cpuReq && (starveCnt == 8'(STARVE_LIMIT));

  always_comb begin
    winner = REQ_NONE;
    if (grantEn) begin
      if (starved)     winner = REQ_CPU;
      else if (bgReq)  winner = REQ_BG;
      else if (sprReq) winner = REQ_SPR;
      else if (cpuReq) winner = REQ_CPU;
    end
  end

  // Counts denied CPU cycles, including those spent blocked by a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (!cpuReq || winner == REQ_CPU) begin
      starveCnt <= '0;
    end else if (starveCnt != 8'(STARVE_LIMIT)) begin
      starveCnt <= starveCnt + 8'd1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Purpose: shares one 256K x 16 async SRAM between BG, SPR (read-only) and CPU (read/write).
// Latency: read grant N -> pins N+1 -> rdata/rvalid N+2; CPU write occupies 3 pin cycles.
// Backpressure: level req held until gnt; no grants during write setup/strobe.
// Ports: clk/rst; {bg,spr,cpu}_req/addr/gnt/rvalid, cpu_we/wdata; shared rdata;
//        ram_addr/ram_dout/ram_ce/oe/we/lb/hb registered SRAM pins, ram_din read data.
// Optional: define VRAM_ARB_STATS_EN for stat_clr input and stat_bg/spr/cpu grant counters.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef VRAM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_bg,
  output logic [15:0]       stat_spr,
  output logic [15:0]       stat_cpu,
`endif
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_gnt,
  output logic              bg_rvalid,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_gnt,
  output logic              spr_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_lb,
  output logic              ram_hb
);

  state_e            state;
  reqId_e            winner;
  reqId_e            rdPipe [RD_LATENCY];
  logic              grantEn;
  logic              cpuWrite;
  logic [ADDR_W-1:0] grantAddr;

  // Reset also blocks grants so nothing is accepted in the reset cycle.
  assign grantEn = !rst && grantWindow(state);

  vram_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) uPrio (
    .clk     (clk),
    .rst     (rst),
    .grantEn (grantEn),
    .bgReq   (bg_req),
    .sprReq  (spr_req),
    .cpuReq  (cpu_req),
    .winner  (winner)
  );

  assign bg_gnt   = (winner == REQ_BG);
  assign spr_gnt  = (winner == REQ_SPR);
  assign cpu_gnt  = (winner == REQ_CPU);
  assign cpuWrite = cpu_gnt && cpu_we;

  always_comb begin
    grantAddr = cpu_addr;
    case (winner)
      REQ_BG:  grantAddr = bg_addr;
      REQ_SPR: grantAddr = spr_addr;
      default: ;
    endcase
  end

  // The last pipe stage names the owner of the rdata register.
  assign bg_rvalid  = (rdPipe[RD_LATENCY-1] == REQ_BG);
  assign spr_rvalid = (rdPipe[RD_LATENCY-1] == REQ_SPR);
  assign cpu_rvalid = (rdPipe[RD_LATENCY-1] == REQ_CPU);

  assign ram_lb = ram_ce;
  assign ram_hb = ram_ce;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ram_addr <= '0;
      ram_dout <= '0;
      ram_ce   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_we   <= 1'b0;
      rdata    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rdPipe[i] <= REQ_NONE;
    end else begin
      rdPipe[0] <= (winner != REQ_NONE && !cpuWrite) ? winner : REQ_NONE;
      for (int i = 1; i < RD_LATENCY; i++) rdPipe[i] <= rdPipe[i-1];
      // The stage before the output is the cycle the SRAM is driving a read.
      if (rdPipe[RD_LATENCY-2] != REQ_NONE) rdata <= ram_din;

      ram_we <= 1'b0;
      case (state)
        WR_SETUP: begin
          state  <= WR_STROBE;
          ram_we <= 1'b1;
        end
        WR_STROBE: state <= WR_HOLD;
        default: begin  // IDLE and WR_HOLD both act as the grant window
          if (cpuWrite) begin
            state    <= WR_SETUP;
            ram_addr <= cpu_addr;
            ram_dout <= cpu_wdata;
            ram_ce   <= 1'b1;
            ram_oe   <= 1'b0;
          end else if (winner != REQ_NONE) begin
            state    <= IDLE;
            ram_addr <= grantAddr;
            ram_ce   <= 1'b1;
            ram_oe   <= 1'b1;
          end else begin
            state  <= IDLE;
            ram_ce <= 1'b0;
            ram_oe <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_bg  <= '0;
      stat_spr <= '0;
      stat_cpu <= '0;
    end else begin
      if (bg_gnt  && stat_bg  != 16'hFFFF) stat_bg  <= stat_bg  + 16'd1;
      if (spr_gnt && stat_spr != 16'hFFFF) stat_spr <= stat_spr + 16'd1;
      if (cpu_gnt && stat_cpu != 16'hFFFF) stat_cpu <= stat_cpu + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then random traffic, every cycle
// compared against a cycle-indexed expectation model of grants, pins and read data.
// Optional stats ports are exercised when VRAM_ARB_STATS_EN is defined.
module tb_vram_arbiter;

  localparam int LIMIT = 32;

  logic        clk, rst;
  logic        bg_req, spr_req, cpu_req, cpu_we;
  logic [17:0] bg_addr, spr_addr, cpu_addr, ram_addr;
  logic [15:0] cpu_wdata, rdata, ram_din, ram_dout;
  logic        bg_gnt, spr_gnt, cpu_gnt, bg_rvalid, spr_rvalid, cpu_rvalid;
  logic        ram_ce, ram_oe, ram_we, ram_lb, ram_hb;
`ifdef VRAM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_bg, stat_spr, stat_cpu;
  logic [15:0] mBg, mSpr, mCpu;
`endif

  vram_arbiter #(.ADDR_W(18), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_bg(stat_bg), .stat_spr(stat_spr), .stat_cpu(stat_cpu),
`endif
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical async SRAM.
  logic [15:0] sram [0:262143];
  function automatic logic [15:0] pat(logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h2A5B};
  endfunction
  initial for (int i = 0; i < 262144; i++) sram[i] = pat(18'(i));
  assign ram_din = (ram_ce && ram_oe) ? sram[ram_addr] : 16'hxxxx;
  always @(posedge clk) if (ram_ce && ram_we) sram[ram_addr] <= ram_dout;

  // Reference model: expected pins / read results per absolute cycle number.
  typedef struct packed { logic ce, oe, we; logic [17:0] addr; logic [15:0] dout; } pin_t;
  typedef struct packed { logic [1:0] id; logic [15:0] data; } rv_t;
  pin_t        pinExp [int];
  rv_t         rvExp  [int];
  logic [15:0] refW   [int];
  int          cyc, blockCyc, starve, mWin, nCmp, nErr;
  logic [17:0] lastAddr;
  logic [15:0] lastDout;
  logic        obsBgGnt, obsCpuGnt, obsCpuRv;
  logic [15:0] obsRdata;

  function automatic logic [15:0] refRead(logic [17:0] a);
    return refW.exists(int'(a)) ? refW[int'(a)] : pat(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already applied; check at negedge, advance model, return at posedge+1.
  task automatic tick();
    int          win;
    pin_t        p;
    rv_t         r;
    logic [17:0] a;
    @(negedge clk);
    win = 0;
    if (!rst && blockCyc == 0) begin
      if (cpu_req && starve == LIMIT) win = 3;
      else if (bg_req)  win = 1;
      else if (spr_req) win = 2;
      else if (cpu_req) win = 3;
    end
    obsBgGnt = bg_gnt; obsCpuGnt = cpu_gnt; obsCpuRv = cpu_rvalid; obsRdata = rdata;
    chk("gnt", {bg_gnt, spr_gnt, cpu_gnt}, {win == 1, win == 2, win == 3});
    p = pinExp.exists(cyc) ? pinExp[cyc] : {3'b000, lastAddr, lastDout};
    chk("pins", {ram_ce, ram_oe, ram_we, ram_addr, ram_dout}, p);
    chk("lanes", {ram_lb, ram_hb}, {p.ce, p.ce});
    r = rvExp.exists(cyc) ? rvExp[cyc] : '0;
    chk("rvalid", {bg_rvalid, spr_rvalid, cpu_rvalid}, {r.id == 2'd1, r.id == 2'd2, r.id == 2'd3});
    if (r.id != 2'd0) chk("rdata", rdata, r.data);
`ifdef VRAM_ARB_STATS_EN
    chk("stats", {stat_bg, stat_spr, stat_cpu}, {mBg, mSpr, mCpu});
    if (rst || stat_clr) begin
      mBg = 0; mSpr = 0; mCpu = 0;
    end else begin
      if (win == 1 && mBg  != 16'hFFFF) mBg++;
      if (win == 2 && mSpr != 16'hFFFF) mSpr++;
      if (win == 3 && mCpu != 16'hFFFF) mCpu++;
    end
`endif
    if (rst) begin
      pinExp.delete(); rvExp.delete();
      blockCyc = 0; starve = 0; lastAddr = '0; lastDout = '0;
    end else begin
      starve = (cpu_req && win != 3) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      if (blockCyc > 0) blockCyc--;
      if (win == 3 && cpu_we) begin
        pinExp[cyc+1] = {3'b100, cpu_addr, cpu_wdata};
        pinExp[cyc+2] = {3'b101, cpu_addr, cpu_wdata};
        pinExp[cyc+3] = {3'b100, cpu_addr, cpu_wdata};
        blockCyc = 2;
        refW[int'(cpu_addr)] = cpu_wdata;
        lastAddr = cpu_addr; lastDout = cpu_wdata;
      end else if (win != 0) begin
        a = (win == 1) ? bg_addr : (win == 2) ? spr_addr : cpu_addr;
        pinExp[cyc+1] = {3'b110, a, lastDout};
        rvExp[cyc+2]  = {2'(win), refRead(a)};
        lastAddr = a;
      end
    end
    mWin = win;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int n;
    int bgPct;
    nCmp = 0; nErr = 0; cyc = 0; blockCyc = 0; starve = 0; mWin = 0;
    lastAddr = '0; lastDout = '0;
    rst = 1'b1; bg_req = 0; spr_req = 0; cpu_req = 0; cpu_we = 0;
    bg_addr = '0; spr_addr = '0; cpu_addr = '0; cpu_wdata = '0;
`ifdef VRAM_ARB_STATS_EN
    stat_clr = 0; mBg = 0; mSpr = 0; mCpu = 0;
`endif
    #1;
    repeat (3) tick();
    chk("rst_rdata", rdata, 16'h0);
    rst = 1'b0;
    tick();

    // Back-to-back BG reads.
    for (int i = 0; i < 4; i++) begin
      bg_req = 1; bg_addr = 18'h02000 + 18'(i);
      tick();
    end
    bg_req = 0;
    repeat (3) tick();

    // All three requesting: BG, then SPR, then CPU.
    bg_req = 1; bg_addr = 18'h00040; spr_req = 1; spr_addr = 18'h00041;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00042;
    tick(); bg_req = 0;
    tick(); spr_req = 0;
    tick(); cpu_req = 0;
    repeat (3) tick();

    // CPU write then read-back.
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h00010; cpu_wdata = 16'h1234;
    tick(); cpu_req = 0;
    repeat (4) tick();
    chk("sram_wr", sram[18'h00010], 16'h1234);
    cpu_req = 1; cpu_we = 0;
    tick(); cpu_req = 0;
    tick(); tick();
    chk("wr_readback", {obsCpuRv, obsRdata}, {1'b1, 16'h1234});
    tick();

    // Starvation: BG hammers, CPU must win on denied cycle LIMIT+1.
    bg_req = 1; bg_addr = 18'h00100; cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00030;
    n = 0;
    while (n < 60) begin
      tick(); n++;
      if (obsCpuGnt) break;
    end
    chk("starve_cycle", 64'(n), 64'(LIMIT + 1));
    cpu_req = 0;
    tick();
    chk("bg_resume", obsBgGnt, 1'b1);
    bg_req = 0;
    repeat (3) tick();

    // Reset during the write strobe.
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h00020; cpu_wdata = 16'hBEEF;
    tick(); cpu_req = 0;
    tick();            // setup
    rst = 1; tick();   // strobe, reset sampled at its end
    rst = 0; tick();   // everything must be idle and zero here
    chk("rst_sram_other", sram[18'h00021], pat(18'h00021));
    chk("rst_sram_prev", sram[18'h00010], 16'h1234);
    tick();

`ifdef VRAM_ARB_STATS_EN
    stat_clr = 1; tick(); stat_clr = 0;
    bg_req = 1; bg_addr = 18'h00005; repeat (5) tick(); bg_req = 0;
    spr_req = 1; spr_addr = 18'h00006; repeat (2) tick(); spr_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00007; tick(); cpu_req = 0;
    chk("stat_cnt", {stat_bg, stat_spr, stat_cpu}, {16'd5, 16'd2, 16'd1});
    tick(); tick();
    stat_clr = 1; tick(); stat_clr = 0;
    chk("stat_clr", {stat_bg, stat_spr, stat_cpu}, 48'h0);
    tick();
`endif

    // Random traffic: a BG-heavy phase to provoke starvation, then a mixed one.
    for (int ph = 0; ph < 2; ph++) begin
      bgPct = (ph == 0) ? 90 : 40;
      for (int c = 0; c < 1500; c++) begin
        if (!(bg_req && mWin != 1)) begin
          bg_req = ($urandom % 100) < bgPct; bg_addr = 18'($urandom_range(0, 63));
        end
        if (!(spr_req && mWin != 2)) begin
          spr_req = ($urandom % 100) < 30; spr_addr = 18'($urandom_range(0, 63));
        end
        if (!(cpu_req && mWin != 3)) begin
          cpu_req = ($urandom % 100) < 30; cpu_we = $urandom % 2;
          cpu_addr = 18'($urandom_range(0, 63)); cpu_wdata = 16'($urandom);
        end
`ifdef VRAM_ARB_STATS_EN
        stat_clr = ($urandom % 200) == 0;
`endif
        tick();
      end
    end
    bg_req = 0; spr_req = 0; cpu_req = 0;
`ifdef VRAM_ARB_STATS_EN
    stat_clr = 0;
`endif
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Single-port SRAM scheduler that shares the 256K x 16 video RAM between three requesters: background tile/char fetch (BG), sprite fetch (SPR) and CPU port (CPU).
- Owns all ram_* pins.
- Issues pipelined single-cycle reads and 3-cycle writes.
- Uses fixed priority BG > SPR > CPU, plus a starvation guarantee for CPU.
- Sits between the layer fetch engines and the external SRAM, in the system clock domain.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, SRAM data width
STARVE_LIMIT, 32, consecutive denied cycles after which CPU becomes top priority (range 1..255)

Ports:
clk  in  1  system clock (not clkPixel)
rst  in  1  synchronous active-high reset
bg_req  in  1  BG request (level)
bg_addr  in  ADDR_W  BG address; read-only port
bg_gnt  out  1  BG request accepted this cycle
bg_rvalid  out  1  BG read data valid
spr_req  in  1  SPR request (level)
spr_addr  in  ADDR_W  SPR address; read-only port
spr_gnt  out  1  SPR accepted
spr_rvalid  out  1  SPR read data valid
cpu_req  in  1  CPU request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU accepted
cpu_rvalid  out  1  CPU read data valid
rdata  out  DATA_W  shared read data, qualified by the *_rvalid strobes
ram_addr  out  ADDR_W  SRAM address (registered)
ram_din  in  DATA_W  SRAM read data
ram_dout  out  DATA_W  SRAM write data (registered)
ram_ce, ram_oe, ram_we  out  1 each  active-high SRAM strobes (registered)
ram_lb, ram_hb  out  1 each  byte lanes; equal to ram_ce

Behaviour:
Reset:
- All outputs 0: gnt, rvalid, rdata, ram_* pins, ram_dout.
- State = IDLE; starvation counter = 0.
- Any in-flight read pipeline is cleared; no rvalid is emitted for it.
- A write interrupted by rst deasserts ram_we on the cycle after rst is sampled.

Grants:
- *_gnt is combinational from the *_req inputs and the state.
- At most one gnt is asserted per cycle.
- Grants are issued only in IDLE, or on the last cycle of a write (WR_HOLD).
- A requester holds addr/we/wdata stable while req=1 and gnt=0. It may change them in the cycle after gnt.

Priority:
- Normal order is BG > SPR > CPU.
- If starve_cnt == STARVE_LIMIT and cpu_req=1, CPU wins over BG and SPR.

Starvation counter (8-bit):
- Increments each cycle where cpu_req=1 and cpu_gnt=0, saturating at STARVE_LIMIT.
- Cleared on cpu_gnt, and cleared when cpu_req=0.

Read timing:
- Grant in cycle N.
- Cycle N+1: ram_addr = granted address; ram_ce = ram_oe = 1; ram_we = 0.
- ram_din is registered at the end of N+1.
- Cycle N+2: rdata is valid and the matching *_rvalid = 1 for exactly one cycle.
- Reads pipeline back-to-back: one grant per cycle, state stays IDLE.

Write timing (CPU only):
- Grant in cycle N; FSM goes IDLE -> WR_SETUP -> WR_STROBE -> WR_HOLD -> IDLE.
- N+1 WR_SETUP: addr and dout driven, ce=1, oe=0, we=0.
- N+2 WR_STROBE: we=1.
- N+3 WR_HOLD: we=0; addr/dout/ce held.
- No grant in N+1 or N+2. A grant may be issued in N+3, with its pins taking effect in N+4.
- A read granted in N-1 still completes: its rvalid appears in N+1, because the data was sampled before setup.

Idle:
- With no grant in the previous cycle, ram_ce = ram_oe = ram_we = 0.
- ram_addr and ram_dout hold their last values.

Simultaneous events:
- Requesters that are not granted receive no gnt and keep waiting.
- rvalid strobes of different requesters never coincide, since there is one grant per cycle.

Optional Feature:
VRAM_ARB_STATS_EN
- With the macro defined, the block adds outputs stat_bg, stat_spr, stat_cpu (16 bits each) and input stat_clr.
- Each stat counter counts grants to its requester and saturates at 0xFFFF.
- stat_clr (synchronous) and rst zero all three counters. Counters are non-wrapping.
- Without the macro, these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
Package vram_arb_pkg:
- requester id enum {REQ_NONE, REQ_BG, REQ_SPR, REQ_CPU}
- FSM state enum {IDLE, WR_SETUP, WR_STROBE, WR_HOLD}
- localparams RD_LATENCY=2 and WR_CYCLES=3

Sub-module vram_arb_priority:
- Combinational winner select.
- Owns the starvation counter register.
- Outputs the winner id.
The top level holds the FSM, pin registers and rvalid id pipeline.

Test Plan:
1. Read pipelining: after rst, bg_req with bg_addr 0x02000..0x02003 held for 4 cycles -> bg_gnt 4 consecutive cycles; ram_addr follows 1 cycle later with ce=oe=1; bg_rvalid 4 cycles starting 2 cycles after the first gnt; rdata matches the SRAM model.
2. Priority: bg_req, spr_req and cpu_req (read) all high at once -> bg_gnt first; spr_gnt once bg_req drops; CPU granted last.
3. Write: CPU write of 0x1234 to 0x00010 -> setup/strobe/hold sequence with we=1 only in the strobe cycle; no gnt for 2 cycles; a later read of 0x00010 returns 0x1234.
4. Starvation: bg_req held high and cpu_req high for 40 cycles with STARVE_LIMIT=32 -> cpu_gnt on the cycle after the counter reaches 32; BG then resumes.
5. Reset mid-write: rst asserted during WR_STROBE -> ram_we=0 and all gnt/rvalid=0 on the next cycle; SRAM model contents are unaffected except at the interrupted address.
6. Stats (VRAM_ARB_STATS_EN): 5 BG grants, 2 SPR grants, 1 CPU grant -> stat counters read 5/2/1; stat_clr -> all 0.
